dark_channel_stream: RTL and testbench
======================================

Name: dark_channel_stream

Overview:
- Streaming dark-channel unit for the dehazer front end.
- Accepts a raster RGB pixel stream and builds 3x3 windows internally with two line buffers per channel.
- Applies edge-aware minimum filtering and emits one dark-channel value per input pixel, in raster order.
- Generalises the per-window dark-channel unit to:
  - parametrised width, image size and threshold;
  - a valid/ready input handshake;
  - end-of-frame flush and border handling.

Parameters:
- DW, 8, bits per colour channel.
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).
- ETH, 20, edge threshold; a pair is an edge when |p-q| > ETH.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input pixel valid.
- in_ready, output, 1, block can accept a pixel.
- in_sof, input, 1, qualifies the first pixel of a frame.
- in_rgb, input, 3*DW, {R,G,B}; R in the MSBs.
- out_valid, output, 1, out_dark valid.
- out_dark, output, DW, dark-channel value.
- out_edge, output, 1, edge flag used for this pixel.
- out_sof, output, 1, first output of a frame.
- out_eol, output, 1, last output of a line.
- out_eof, output, 1, last output of a frame.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - outputs: out_* = 0, in_ready = 1;
  - FSM = IDLE;
  - row/col counters = 0;
  - line-buffer contents don't-care.
- Accept rule: a beat is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: wait for an accepted beat with in_sof=1. Beats without in_sof are dropped. On in_sof, go to RUN with that pixel at row 0, col 0.
  - RUN: each accepted beat advances col, and row when col wraps from IMG_W-1 to 0. On acceptance of pixel (IMG_H-1, IMG_W-1), go to FLUSH.
  - FLUSH: in_ready=0. Generate IMG_W+1 internal flush beats, one per cycle, then go to IDLE.
- Emission rule:
  - The output for raster index k is triggered by the beat with index k+IMG_W+1 (accepted or flush).
  - Exactly IMG_W*IMG_H outputs are produced per frame.
- Latency: out_valid asserts exactly 2 cycles after the triggering beat.
  - Stage 1 registers the window and compute.
  - Stage 2 registers the outputs.
  - No stall; out_valid is high for 1 cycle per trigger.
- Interior pixel (1<=r<=IMG_H-2, 1<=c<=IMG_W-2), using neighbours a..i with e as centre:
  - per channel, E = OR over the pairs (a,i), (b,h), (c,g), (d,f) of |x-y| > ETH. The difference is unsigned DW-bit and the absolute value is taken on a true DW+1 difference, with no wrap error at 0 vs 255.
  - sel = E_R | E_G | E_B.
  - per channel, m = sel ? centre : min of the 8 neighbours. The centre is excluded from the min.
  - out_dark = min(m_R, m_G, m_B); out_edge = sel.
- Border pixel (row 0, row IMG_H-1, col 0, col IMG_W-1): out_dark = min of the centre R, G, B; out_edge = 0.
- Markers:
  - out_sof on output (0,0).
  - out_eol on col IMG_W-1.
  - out_eof on (IMG_H-1, IMG_W-1).
- Simultaneous/abnormal events:
  - in_sof in RUN resynchronises to a new frame at (0,0). Pending outputs of the abandoned frame are discarded; nothing is emitted for them.
  - in_sof on the last pixel is treated as a resync, not end-of-frame.
  - in_valid during FLUSH is ignored, since in_ready=0.
  - rst mid-frame or mid-flush: immediate return to reset state; in-flight outputs are lost.
- Arithmetic: all comparisons are unsigned DW-bit; no saturation is needed.

Optional Feature:
- Macro DCS_EDGE_COUNT_EN.
- When defined:
  - adds output edge_count, width ceil(log2(IMG_W*IMG_H+1)), reset to 0;
  - counts out_valid&&out_edge within the current frame;
  - the total is latched to edge_count on the out_eof cycle and held until the next out_eof;
  - the internal accumulator clears on out_sof.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- IMG_W=IMG_H=4, all pixels R=G=B=50 -> 16 outputs.
  - out_dark=50, out_edge=0 on every output;
  - out_sof at the first, out_eol every 4th, out_eof at the 16th;
  - in_ready low for exactly 5 cycles after the last input.
- 4x4 frame, pixel (1,1) neighbours R all 100, G all 80, B all 60 except B at (0,0)=10 (diff vs (2,2) = 50 > 20):
  - output (1,1) has out_edge=1 and out_dark = min of centre R/G/B (centre = 70,70,70) -> 70.
- Same frame with B(0,0)=45 (diff 15) -> out_edge=0; out_dark=min(100,80,45)=45.
- Latency check: first output asserts 2 cycles after beat index 5 is accepted. Back-to-back frames with gaps in in_valid -> output order and values are unchanged.
- in_sof reasserted at row 2 mid-frame -> no outputs from the abandoned frame after the resync point; the new frame produces 16 correct outputs.
- rst pulse during FLUSH -> outputs clear asynchronously, in_ready=1, FSM idle. The next frame is correct. With DCS_EDGE_COUNT_EN, edge_count=0 after reset and equals 1 after the frame of test 2.

Source files
------------

// File: rtl/dark_channel_stream.sv
// Streaming 3x3 edge-aware dark-channel filter over a raster RGB stream, with end-of-frame flush.
// Optional per-frame edge counter output when DCS_EDGE_COUNT_EN is defined.
module dark_channel_stream #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned ETH   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [3*DW-1:0]   in_rgb,
  output logic              out_valid,
  output logic [DW-1:0]     out_dark,
  output logic              out_edge,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof
`ifdef DCS_EDGE_COUNT_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_count
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic [RW-1:0]     row_q, orow_q, pos_row_c, row_d;
  logic [CW-1:0]     col_q, ocol_q, pos_col_c, col_d;
  logic              s1_valid_q, s1_border_q, s1_sof_q, s1_eol_q, s1_eof_q;
  logic              out_valid_q, out_edge_q, out_sof_q, out_eol_q, out_eof_q;
  logic [DW-1:0]     out_dark_q;
  logic [3*DW-1:0]   lb1_q [IMG_W];
  logic [3*DW-1:0]   lb2_q [IMG_W];
  logic [3*DW-1:0]   win_q [3][3];
  logic [3*DW-1:0]   pix_c;
  logic              acc_c, sof_beat_c, resync_c, beat_c, trig_c, last_in_c, last_flush_c;
  logic              sel_c, edge_d;
  logic [DW-1:0]     m_c, ctr_c, dark_d;

  function automatic logic [DW-1:0] chan(input logic [3*DW-1:0] p, input int ch);
    return p[ch*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic is_edge(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return d > DW'(ETH);
  endfunction

  // Beat decode: accepted pixels in a frame plus synthetic flush beats.
  always_comb begin
    acc_c        = in_valid && in_ready_q;
    sof_beat_c   = acc_c && in_sof;
    resync_c     = sof_beat_c && (state_q == S_RUN);
    beat_c       = (acc_c && (in_sof || state_q == S_RUN)) || (state_q == S_FLUSH);
    pix_c        = (state_q == S_FLUSH) ? '0 : in_rgb;
    pos_row_c    = sof_beat_c ? '0 : row_q;
    pos_col_c    = sof_beat_c ? '0 : col_q;
    col_d        = (pos_col_c == CW'(IMG_W - 1)) ? '0 : pos_col_c + CW'(1);
    row_d        = (pos_col_c == CW'(IMG_W - 1)) ? pos_row_c + RW'(1) : pos_row_c;
    trig_c       = beat_c && ((pos_row_c >= RW'(2)) || (pos_row_c == RW'(1) && pos_col_c != '0));
    last_in_c    = acc_c && !in_sof && (state_q == S_RUN) &&
                   (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    last_flush_c = (state_q == S_FLUSH) && (row_q == RW'(IMG_H + 1));
  end

  // Line buffers and window shift; contents need no reset.
  always_ff @(posedge clk) begin
    if (beat_c) begin
      lb1_q[pos_col_c] <= pix_c;
      lb2_q[pos_col_c] <= lb1_q[pos_col_c];
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_q[pos_col_c];
      win_q[1][2] <= lb1_q[pos_col_c];
      win_q[2][2] <= pix_c;
    end
  end

  // Window datapath: edge detect over opposite pairs, then centre or neighbour minimum.
  always_comb begin
    sel_c  = 1'b0;
    m_c    = '0;
    ctr_c  = '1;
    dark_d = '1;
    edge_d = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      sel_c = sel_c
            | is_edge(chan(win_q[0][0], ch), chan(win_q[2][2], ch))
            | is_edge(chan(win_q[0][1], ch), chan(win_q[2][1], ch))
            | is_edge(chan(win_q[0][2], ch), chan(win_q[2][0], ch))
            | is_edge(chan(win_q[1][0], ch), chan(win_q[1][2], ch));
    end
    for (int ch = 0; ch < 3; ch++) begin
      m_c = chan(win_q[0][0], ch);
      m_c = min2(m_c, chan(win_q[0][1], ch));
      m_c = min2(m_c, chan(win_q[0][2], ch));
      m_c = min2(m_c, chan(win_q[1][0], ch));
      m_c = min2(m_c, chan(win_q[1][2], ch));
      m_c = min2(m_c, chan(win_q[2][0], ch));
      m_c = min2(m_c, chan(win_q[2][1], ch));
      m_c = min2(m_c, chan(win_q[2][2], ch));
      if (sel_c) m_c = chan(win_q[1][1], ch);
      dark_d = min2(dark_d, m_c);
      ctr_c  = min2(ctr_c, chan(win_q[1][1], ch));
    end
    edge_d = sel_c;
    if (s1_border_q) begin
      dark_d = ctr_c;
      edge_d = 1'b0;
    end
  end

  // Control FSM, position counters and output pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      row_q       <= '0;
      col_q       <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_border_q <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_dark_q  <= '0;
      out_edge_q  <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      if (beat_c) begin
        row_q <= row_d;
        col_q <= col_d;
      end
      case (state_q)
        S_IDLE:  if (sof_beat_c) state_q <= S_RUN;
        S_RUN:   if (last_in_c) begin
                   state_q    <= S_FLUSH;
                   in_ready_q <= 1'b0;
                 end
        S_FLUSH: if (last_flush_c) begin
                   state_q    <= S_IDLE;
                   in_ready_q <= 1'b1;
                 end
        default: state_q <= S_IDLE;
      endcase
      if (sof_beat_c) begin
        orow_q <= '0;
        ocol_q <= '0;
      end else if (trig_c) begin
        ocol_q <= (ocol_q == CW'(IMG_W - 1)) ? '0 : ocol_q + CW'(1);
        if (ocol_q == CW'(IMG_W - 1)) orow_q <= orow_q + RW'(1);
      end
      s1_valid_q  <= trig_c;
      s1_border_q <= (orow_q == '0) || (orow_q == RW'(IMG_H - 1)) ||
                     (ocol_q == '0) || (ocol_q == CW'(IMG_W - 1));
      s1_sof_q    <= (orow_q == '0) && (ocol_q == '0);
      s1_eol_q    <= (ocol_q == CW'(IMG_W - 1));
      s1_eof_q    <= (orow_q == RW'(IMG_H - 1)) && (ocol_q == CW'(IMG_W - 1));
      // A resync drops whatever the abandoned frame still has in flight.
      out_valid_q <= s1_valid_q && !resync_c;
      out_sof_q   <= s1_valid_q && !resync_c && s1_sof_q;
      out_eol_q   <= s1_valid_q && !resync_c && s1_eol_q;
      out_eof_q   <= s1_valid_q && !resync_c && s1_eof_q;
      out_edge_q  <= s1_valid_q && !resync_c && edge_d;
      if (s1_valid_q && !resync_c) out_dark_q <= dark_d;
    end
  end

`ifdef DCS_EDGE_COUNT_EN
  localparam int unsigned ECW = $clog2(IMG_W*IMG_H+1);
  logic [ECW-1:0] ecnt_acc_q, edge_count_q, ecnt_sum_c;

  always_comb ecnt_sum_c = (s1_sof_q ? '0 : ecnt_acc_q) + ECW'(edge_d);

  // Running count per frame, published together with the end-of-frame output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt_acc_q   <= '0;
      edge_count_q <= '0;
    end else if (s1_valid_q && !resync_c) begin
      ecnt_acc_q <= ecnt_sum_c;
      if (s1_eof_q) edge_count_q <= ecnt_sum_c;
    end
  end

  assign edge_count = edge_count_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dark  = out_dark_q;
  assign out_edge  = out_edge_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_dark_channel_stream.sv
// Directed bench for dark_channel_stream on 4x4 frames with hand-computed expectations.
module tb_dark_channel_stream;

  typedef struct packed {
    logic [7:0] dark;
    logic       edg;
    logic       sof;
    logic       eol;
    logic       eof;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sof;
  logic [23:0] in_rgb;
  logic        out_valid, out_edge, out_sof, out_eol, out_eof;
  logic [7:0]  out_dark;
`ifdef DCS_EDGE_COUNT_EN
  logic [4:0]  edge_count;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   acc_cyc [16];
  obs_t q [$];
  int   ocyc [$];

  logic [23:0] fu [16];
  logic [23:0] fa [16];
  logic [23:0] fb [16];
  int eu [16] = '{default: 50};
  int ea [16] = '{10, 60, 60, 60, 60, 70, 60, 70, 60, 60, 60, 60, 60, 70, 60, 70};
  int eb [16] = '{45, 60, 60, 60, 60, 45, 60, 70, 60, 60, 60, 60, 60, 70, 60, 70};

  dark_channel_stream #(.DW(8), .IMG_W(4), .IMG_H(4), .ETH(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_dark  (out_dark),
    .out_edge  (out_edge),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
`ifdef DCS_EDGE_COUNT_EN
    ,
    .edge_count(edge_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q.push_back({out_dark, out_edge, out_sof, out_eol, out_eof});
      ocyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_pix(input logic [23:0] rgb, input logic sof, output int acc);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_timeout", int'(guard < 100), 1);
    in_valid = 1'b1;
    in_rgb   = rgb;
    in_sof   = sof;
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] f [16], input logic [15:0] gap);
    for (int i = 0; i < 16; i++) begin
      send_pix(f[i], i == 0, acc_cyc[i]);
      if (gap[i]) @(negedge clk);
    end
  endtask

  task automatic wait_q(input string tag, input int n);
    int g = 0;
    while (q.size() < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    chk(tag, q.size(), n);
  endtask

  task automatic check_frame(input string tag, input int base, input int ex [16],
                             input logic [15:0] em);
    for (int i = 0; i < 16; i++) begin
      if (base + i < q.size()) begin
        chk($sformatf("%s_dark%0d", tag, i), int'(q[base+i].dark), ex[i]);
        chk($sformatf("%s_edge%0d", tag, i), int'(q[base+i].edg), int'(em[i]));
        chk($sformatf("%s_mark%0d", tag, i), int'({q[base+i].sof, q[base+i].eol, q[base+i].eof}),
            int'({i == 0, (i % 4) == 3, i == 15}));
      end else begin
        chk($sformatf("%s_missing%0d", tag, i), q.size(), base + i + 1);
      end
    end
  endtask

  initial begin
    int dummy;
    int lo;
    for (int i = 0; i < 16; i++) begin
      fu[i] = 24'h323232;
      fa[i] = 24'h64503C;
    end
    fa[5]  = 24'h464646;
    fa[7]  = 24'h464646;
    fa[13] = 24'h464646;
    fa[15] = 24'h464646;
    fb     = fa;
    fa[0]  = 24'h64500A;
    fb[0]  = 24'h64502D;

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_rgb = '0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_dark", int'(out_dark), 0);
    chk("rst_markers", int'({out_edge, out_sof, out_eol, out_eof}), 0);
`ifdef DCS_EDGE_COUNT_EN
    chk("rst_edge_count", int'(edge_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Beats without sof in IDLE are dropped.
    send_pix(24'h101010, 1'b0, dummy);
    send_pix(24'h101010, 1'b0, dummy);
    repeat (10) @(negedge clk);
    chk("idle_drop", q.size(), 0);

    // Uniform frame: latency, markers, flush length.
    send_frame(fu, 16'h0000);
    lo = 0;
    @(negedge clk);
    while (!in_ready && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    chk("flush_ready_low", lo, 5);
    wait_q("u_count", 16);
    if (q.size() > 0) chk("latency", ocyc[0], acc_cyc[5] + 1);
    check_frame("u", 0, eu, 16'h0000);

    // Back-to-back frames A (edge at 1,1) and B (no edge), B with input gaps.
    q.delete(); ocyc.delete();
    send_frame(fa, 16'h0000);
    send_frame(fb, 16'b0101_0010_1000_0110);
    wait_q("ab_count", 32);
    check_frame("a", 0, ea, 16'h0020);
    check_frame("b", 16, eb, 16'h0000);
`ifdef DCS_EDGE_COUNT_EN
    chk("ecnt_after_b", int'(edge_count), 0);
`endif

    // Resync at row 2: two old outputs delivered, the pending one dropped.
    q.delete(); ocyc.delete();
    for (int i = 0; i < 8; i++) send_pix(fu[i], i == 0, dummy);
    send_frame(fa, 16'h0000);
    wait_q("rs_count", 18);
    if (q.size() >= 2) begin
      chk("rs_old0", int'({q[0].dark, q[0].sof}), int'({8'd50, 1'b1}));
      chk("rs_old1", int'({q[1].dark, q[1].sof}), int'({8'd50, 1'b0}));
    end
    check_frame("rs", 2, ea, 16'h0020);

    // Reset during flush, then a clean frame A.
    send_frame(fb, 16'h0000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("fr_out_valid", int'(out_valid), 0);
    chk("fr_in_ready", int'(in_ready), 1);
    chk("fr_out_dark", int'(out_dark), 0);
`ifdef DCS_EDGE_COUNT_EN
    chk("fr_edge_count", int'(edge_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    q.delete(); ocyc.delete();
    send_frame(fa, 16'h0000);
    wait_q("post_rst_count", 16);
    check_frame("pr", 0, ea, 16'h0020);
`ifdef DCS_EDGE_COUNT_EN
    chk("ecnt_after_a", int'(edge_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
